// File: rtl/demux_slot_sequencer.sv
// Serialises a 4-bit word onto F while stepping the demux select {b,a} through channels 0..3.
// Optional build macro SEQ_BLANK_EN forces F low for the first cycle of every slot.
module demux_slot_sequencer #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] data_in,
  output logic       in_ready,
  output logic       b,
  output logic       a,
  output logic       F,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // A hold of 0 would never advance the slot, so it is promoted to 1.
  localparam int              HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_EFF - 1);

  state_t           state, state_nxt;
  logic [1:0]       slot, slot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       word, word_nxt;
  logic             b_nxt, a_nxt, f_nxt, busy_nxt, done_nxt;

  assign in_ready = (state == IDLE);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cnt_nxt   = cnt;
    word_nxt  = word;
    b_nxt     = 1'b0;
    a_nxt     = 1'b0;
    f_nxt     = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          word_nxt  = data_in;
          slot_nxt  = 2'd0;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        busy_nxt       = 1'b1;
        {b_nxt, a_nxt} = slot;
        f_nxt          = word[slot];
`ifdef SEQ_BLANK_EN
        if (HOLD_EFF >= 2 && cnt == '0) f_nxt = 1'b0;
`endif
        // Slot wrap and exit to DONE share one edge, so no fifth select code is ever registered.
        if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          slot_nxt = slot + 2'd1;
          if (slot == 2'd3) state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the decoded state, so the demux sees glitch-free select and data.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= 2'd0;
      cnt   <= '0;
      word  <= 4'd0;
      b     <= 1'b0;
      a     <= 1'b0;
      F     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      slot  <= slot_nxt;
      cnt   <= cnt_nxt;
      word  <= word_nxt;
      b     <= b_nxt;
      a     <= a_nxt;
      F     <= f_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_demux_slot_sequencer.sv
// Scoreboard bench for demux_slot_sequencer: stimulus queues expected {b,a,F,done} per busy cycle,
// a negedge monitor pops and compares whenever busy is high. Honours SEQ_BLANK_EN and H override.
module tb_demux_slot_sequencer #(
  parameter int H = 10
);

`ifdef SEQ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [3:0] outs;    // {b,a,F,done}
    int         at_cyc;  // posedge index after which this value must be visible
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] data_in;
  logic       in_ready, b, a, F, busy, done;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  demux_slot_sequencer #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready), .b(b), .a(a), .F(F), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected output stream for a word accepted at edge k.
  task automatic push_frame(input logic [3:0] w, input int k);
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < H; c++) begin
        logic fe;
        fe = (BLANK && H >= 2 && c == 0) ? 1'b0 : w[s];
        e.outs   = {s[1:0], fe, 1'b0};
        e.at_cyc = k + 1 + s * H + c;
        q.push_back(e);
      end
    end
    e.outs   = 4'b0001;
    e.at_cyc = k + 1 + 4 * H;
    q.push_back(e);
  endtask

  // Monitor: one expected entry per busy cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && busy) begin
        if (q.size() == 0) begin
          check("spurious_busy", busy, 0);
        end else begin
          e = q.pop_front();
          check("outs_baFd", {b, a, F, done}, e.outs);
          check("outs_cycle", cyc, e.at_cyc);
        end
      end
    end
  end

  task automatic accept(input logic [3:0] w, output int k);
    in_valid = 1'b1;
    data_in  = w;
    @(posedge clk);
    #1;
    k = cyc;
    push_frame(w, k);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8 * H + 20; i++) begin
      @(posedge clk);
      #1;
      if (!busy && q.size() == 0) break;
    end
    check("frame_drained", q.size(), 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    int k;
    // Reset held with in_valid high: nothing captured.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    data_in  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {b, a, F, busy, done}, 0);
    check("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Basic frame 1010.
    accept(4'b1010, k);
    #1 check("in_ready_busy", in_ready, 0);
    repeat (4 * H + 2) @(posedge clk);
    #1;
    check("k42_in_ready", in_ready, 1);
    check("k42_done", done, 0);
    wait_idle();

    // Stray in_valid during slot 2 is ignored.
    accept(4'b0101, k);
    repeat (2 * H + 3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    data_in  = 4'b1111;
    check("slot2_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // in_valid held high: second word taken on the first IDLE edge, k+4H+2.
    in_valid = 1'b1;
    data_in  = 4'b0001;
    @(posedge clk);
    #1;
    k = cyc;
    push_frame(4'b0001, k);
    push_frame(4'b1000, k + 4 * H + 2);
    data_in = 4'b1000;
    repeat (4 * H + 2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset mid-frame: outputs clear at once, frame dropped, no done.
    accept(4'b0110, k);
    repeat (2 * H + 3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outs", {b, a, F, busy, done}, 0);
    check("midrst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle_busy", busy, 0);
    accept(4'b0100, k);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
